// File: rtl/ex_mem_pkg.sv
// Shared widths, constants and mode decoding for the EX/MEM pipeline register.
// Imported by ex_mem; the optional flush feature is selected with EX_MEM_FLUSH_EN.
package ex_mem_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int DREG_BUS_W     = 64;
  localparam int CNT_BUS_W      = 2;
  localparam int STALL_W        = 6;
  localparam int EX_STALL_BIT   = 3;
  localparam int MEM_STALL_BIT  = 4;

  localparam logic [REG_BUS_W-1:0]      ZERO_WORD     = 32'h0000_0000;
  localparam logic [DREG_BUS_W-1:0]     ZERO_DWORD    = 64'h0000_0000_0000_0000;
  localparam logic [REG_ADDR_BUS_W-1:0] NOP_REG_ADDR  = 5'b00000;
  localparam logic [CNT_BUS_W-1:0]      CNT_IDLE      = 2'b00;
  localparam logic                      RST_ENABLE    = 1'b1;
  localparam logic                      STOP          = 1'b1;
  localparam logic                      NO_STOP       = 1'b0;
  localparam logic                      WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_BUBBLE = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_FLUSH  = 2'b11
  } mode_e;

  // EX running while MEM is stalled cannot legally happen; it is treated as normal.
  function automatic mode_e decode_mode(input logic ex_stop, input logic mem_stop,
                                        input logic flush_req);
    mode_e m;
    if (flush_req == 1'b1) begin
      m = MODE_FLUSH;
    end else if (ex_stop == NO_STOP) begin
      m = MODE_NORMAL;
    end else if (mem_stop == NO_STOP) begin
      m = MODE_BUBBLE;
    end else begin
      m = MODE_HOLD;
    end
    return m;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with multiply-accumulate feedback (hilo_o/cnt_o).
// Define EX_MEM_FLUSH_EN to add the flush port and its zeroing behaviour.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
`ifdef EX_MEM_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic [REG_ADDR_BUS_W-1:0] ex_wd,
  input  logic                      ex_wreg,
  input  logic [REG_BUS_W-1:0]      ex_wdata,
  input  logic [DREG_BUS_W-1:0]     ex_hilo_temp,
  input  logic [CNT_BUS_W-1:0]      ex_cnt,
  output logic [REG_ADDR_BUS_W-1:0] mem_wd,
  output logic                      mem_wreg,
  output logic [REG_BUS_W-1:0]      mem_wdata,
  output logic [DREG_BUS_W-1:0]     hilo_o,
  output logic [CNT_BUS_W-1:0]      cnt_o
);

  logic [REG_ADDR_BUS_W-1:0] mem_wd_q,    mem_wd_d;
  logic                      mem_wreg_q,  mem_wreg_d;
  logic [REG_BUS_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic [DREG_BUS_W-1:0]     hilo_q,      hilo_d;
  logic [CNT_BUS_W-1:0]      cnt_q,       cnt_d;
  logic                      flush_s;
  mode_e                     mode_s;
  logic                      unused_stall_bits;

`ifdef EX_MEM_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Only the EX and MEM stall bits matter to this stage.
  assign unused_stall_bits = ^{stall[5], stall[2:0]};
  assign mode_s = decode_mode(stall[EX_STALL_BIT], stall[MEM_STALL_BIT], flush_s);

  // Next-state selection per pipeline mode; accumulation state lives in cnt_q.
  always_comb begin
    mem_wd_d    = mem_wd_q;
    mem_wreg_d  = mem_wreg_q;
    mem_wdata_d = mem_wdata_q;
    hilo_d      = hilo_q;
    cnt_d       = cnt_q;
    case (mode_s)
      MODE_FLUSH: begin
        mem_wd_d    = NOP_REG_ADDR;
        mem_wreg_d  = WRITE_DISABLE;
        mem_wdata_d = ZERO_WORD;
        hilo_d      = ZERO_DWORD;
        cnt_d       = CNT_IDLE;
      end
      MODE_BUBBLE: begin
        mem_wd_d    = NOP_REG_ADDR;
        mem_wreg_d  = WRITE_DISABLE;
        mem_wdata_d = ZERO_WORD;
        hilo_d      = ex_hilo_temp;
        cnt_d       = ex_cnt;
      end
      MODE_NORMAL: begin
        mem_wd_d    = ex_wd;
        mem_wreg_d  = ex_wreg;
        mem_wdata_d = ex_wdata;
        hilo_d      = ZERO_DWORD;
        cnt_d       = CNT_IDLE;
      end
      MODE_HOLD: begin
        mem_wd_d    = mem_wd_q;
        mem_wreg_d  = mem_wreg_q;
        mem_wdata_d = mem_wdata_q;
        hilo_d      = hilo_q;
        cnt_d       = cnt_q;
      end
      default: begin
        mem_wd_d    = mem_wd_q;
        mem_wreg_d  = mem_wreg_q;
        mem_wdata_d = mem_wdata_q;
        hilo_d      = hilo_q;
        cnt_d       = cnt_q;
      end
    endcase
  end

  // State register; reset wins over every other mode.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      mem_wd_q    <= NOP_REG_ADDR;
      mem_wreg_q  <= WRITE_DISABLE;
      mem_wdata_q <= ZERO_WORD;
      hilo_q      <= ZERO_DWORD;
      cnt_q       <= CNT_IDLE;
    end else begin
      mem_wd_q    <= mem_wd_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_wdata_q <= mem_wdata_d;
      hilo_q      <= hilo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_wd    = mem_wd_q;
  assign mem_wreg  = mem_wreg_q;
  assign mem_wdata = mem_wdata_q;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset (`RstEnable` = 1'b1), sampled on clk rising edge only.
REQ-004 stall  input  6  pipeline stall vector; bit 3 = EX stalled, bit 4 = MEM stalled; other bits ignored.
REQ-005 flush  input  1  pipeline flush request; present only when EX_MEM_FLUSH_EN is defined.
REQ-006 ex_wd  input  5  destination register address from EX.
REQ-007 ex_wreg  input  1  register write enable from EX.
REQ-008 ex_wdata  input  32  result data from EX.
REQ-009 ex_hilo_temp  input  64  partial multiply-accumulate product from EX.
REQ-010 ex_cnt  input  2  multi-cycle step count from EX.
REQ-011 mem_wd  output  5  registered destination address to MEM.
REQ-012 mem_wreg  output  1  registered write enable to MEM.
REQ-013 mem_wdata  output  32  registered result to MEM.
REQ-014 hilo_o  output  64  partial product fed back to EX.
REQ-015 cnt_o  output  2  step count fed back to EX.

Function
REQ-016 Every update SHALL occur only on the rising edge of clk; all outputs are registered, with no combinational input-to-output path.
REQ-017 Mode priority per edge SHALL be: rst, then flush (if compiled in), then bubble, then normal, then hold.
REQ-018 Normal mode, stall[3]=0, SHALL capture ex_wd/ex_wreg/ex_wdata into mem_* and clear hilo_o and cnt_o to 0, giving a latency of exactly 1 cycle.
REQ-019 Bubble mode, stall[3]=1 with stall[4]=0, SHALL load mem_wd=0, mem_wreg=0, mem_wdata=0, hilo_o<=ex_hilo_temp, and cnt_o<=ex_cnt.
REQ-020 Hold mode, stall[3]=1 with stall[4]=1, SHALL keep every output at its previous value.
REQ-021 stall[3]=0 with stall[4]=1 is illegal upstream; the block SHALL treat it as normal mode, and the bench SHALL flag it.
REQ-022 The accumulation state machine SHALL be implicit in cnt_o: it holds 2'b00 when idle, takes ex_cnt across consecutive bubble cycles, and returns to 2'b00 on the first normal cycle.
REQ-023 All data SHALL pass through unmodified, with no arithmetic, truncation or sign extension.
REQ-024 A reset or flush asserted mid-accumulation SHALL discard hilo_o and cnt_o, setting both to 0.

Reset
REQ-025 When rst=1 at an edge, all outputs SHALL become 0, with mem_wd equal to `NOPRegAddr`.
REQ-026 Reset SHALL override stall and flush on the same edge.

Configuration
REQ-027 The macro EX_MEM_FLUSH_EN SHALL control the flush feature.
REQ-028 With EX_MEM_FLUSH_EN defined, the flush port SHALL exist, and flush=1 SHALL zero all outputs on the next edge regardless of stall.
REQ-029 With EX_MEM_FLUSH_EN undefined, the flush port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-030 Widths and constants SHALL come from the shared defines.v, including `RegBus`, `RegAddrBus`, `DoubleRegBus`, `ZeroWord`, `NOPRegAddr`, `RstEnable`, `Stop`, `NoStop` and `WriteDisable`, plus a new `CntBus` (2 bits).
REQ-031 The block SHALL be a single flat module with no sub-module.

Verification
REQ-032 Normal transfer: apply ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h0000_1234 with stall=0 -> after one edge, mem_wd=3, mem_wreg=1, mem_wdata=32'h1234, hilo_o=0, cnt_o=0.
REQ-033 Bubble then resume: hold stall=6'b001000 for 2 edges with ex_hilo_temp=64'h1_0000_0002 and ex_cnt=1 -> mem_wreg=0, hilo_o=64'h1_0000_0002, cnt_o=1; then stall=0 -> cnt_o=0, hilo_o=0.
REQ-034 Hold: load data 32'hAAAA_5555, then set stall=6'b011000 for 3 edges with new inputs 32'hFFFF_FFFF -> mem_wdata stays 32'hAAAA_5555.
REQ-035 Reset mid-accumulation: with cnt_o=1 and hilo_o nonzero, pulse rst=1 together with stall=6'b001000 -> all outputs 0 and mem_wd=0 after the edge.
REQ-036 Flush (EX_MEM_FLUSH_EN defined): with flush=1, stall=6'b011000 and mem_wdata=32'h55 -> all outputs 0 on the next edge; rebuild without the macro and run REQ-032 to REQ-035 unchanged.
